// File: rtl/dpram_port_master_if.sv
// Request/response and RAM-port bundle for dpram_port_master.
// iReqBe exists only when DPRAM_RMW_BYTE_EN is defined.
interface dpram_port_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                    iReqValid;
  logic                    oReqReady;
  logic                    iReqWe;
  logic [ADDR_WIDTH-1:0]   iReqAddr;
  logic [DATA_WIDTH-1:0]   iReqData;
`ifdef DPRAM_RMW_BYTE_EN
  logic [DATA_WIDTH/8-1:0] iReqBe;
`endif
  logic                    oRspValid;
  logic                    iRspReady;
  logic [DATA_WIDTH-1:0]   oRspData;
  logic                    oRamEn;
  logic                    oRamWe;
  logic [ADDR_WIDTH-1:0]   oRamAddr;
  logic [DATA_WIDTH-1:0]   oRamData;
  logic [DATA_WIDTH-1:0]   iRamData;

  modport master (
    input  iReqValid, iReqWe, iReqAddr, iReqData, iRspReady, iRamData,
    output oReqReady, oRspValid, oRspData, oRamEn, oRamWe, oRamAddr, oRamData
`ifdef DPRAM_RMW_BYTE_EN
    , input iReqBe
`endif
  );

  modport slave (
    output iReqValid, iReqWe, iReqAddr, iReqData, iRspReady, iRamData,
    input  oReqReady, oRspValid, oRspData, oRamEn, oRamWe, oRamAddr, oRamData
`ifdef DPRAM_RMW_BYTE_EN
    , output iReqBe
`endif
  );
endinterface

// File: rtl/dpram_port_master.sv
// Single-outstanding initiator for one DualPortRAM port; registered RAM drive, valid/ready response.
// Define DPRAM_RMW_BYTE_EN to add byte-enabled writes via read-modify-write.
//
// state  | meaning
// IDLE   | ready for a request
// WR     | write strobe issued, dropping enable
// RD     | read issued, capturing RAM data
// RSP    | holding read data until accepted
// RMW_RD | partial write: old word being read
// RMW_WR | partial write: merged word being written
module dpram_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic iClk,
  input logic iRst,
  dpram_port_master_if.master bus
);
`ifdef DPRAM_RMW_BYTE_EN
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, WR, RD, RSP, RMW_RD, RMW_WR} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR, RD, RSP} state_t;
`endif

  state_t                  state, stateNxt;
  logic                    rspValid, rspValidNxt;
  logic [DATA_WIDTH-1:0]   rspData, rspDataNxt;
  logic                    ramEn, ramEnNxt;
  logic                    ramWe, ramWeNxt;
  logic [ADDR_WIDTH-1:0]   ramAddr, ramAddrNxt;
  logic [DATA_WIDTH-1:0]   ramData, ramDataNxt;
`ifdef DPRAM_RMW_BYTE_EN
  logic [BE_WIDTH-1:0]     beQ, beNxt;
`endif

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      rspValid <= 1'b0;
      rspData  <= '0;
      ramEn    <= 1'b0;
      ramWe    <= 1'b0;
      ramAddr  <= '0;
      ramData  <= '0;
`ifdef DPRAM_RMW_BYTE_EN
      beQ      <= '0;
`endif
    end else begin
      state    <= stateNxt;
      rspValid <= rspValidNxt;
      rspData  <= rspDataNxt;
      ramEn    <= ramEnNxt;
      ramWe    <= ramWeNxt;
      ramAddr  <= ramAddrNxt;
      ramData  <= ramDataNxt;
`ifdef DPRAM_RMW_BYTE_EN
      beQ      <= beNxt;
`endif
    end
  end

  always_comb begin
    stateNxt    = state;
    rspValidNxt = rspValid;
    rspDataNxt  = rspData;
    ramEnNxt    = 1'b0;
    ramWeNxt    = 1'b0;
    ramAddrNxt  = ramAddr;
    ramDataNxt  = ramData;
`ifdef DPRAM_RMW_BYTE_EN
    beNxt       = beQ;
`endif
    case (state)
      IDLE: begin
        if (bus.iReqValid) begin
          ramAddrNxt = bus.iReqAddr;
          ramDataNxt = bus.iReqData;
          if (bus.iReqWe) begin
`ifdef DPRAM_RMW_BYTE_EN
            if (&bus.iReqBe) begin
              ramEnNxt = 1'b1;
              ramWeNxt = 1'b1;
              stateNxt = WR;
            end else if (bus.iReqBe != '0) begin
              // Fetch the old word first; ramData keeps the new bytes until the merge.
              ramEnNxt = 1'b1;
              beNxt    = bus.iReqBe;
              stateNxt = RMW_RD;
            end
`else
            ramEnNxt = 1'b1;
            ramWeNxt = 1'b1;
            stateNxt = WR;
`endif
          end else begin
            ramEnNxt = 1'b1;
            stateNxt = RD;
          end
        end
      end
      WR: stateNxt = IDLE;
      RD: begin
        rspValidNxt = 1'b1;
        rspDataNxt  = bus.iRamData;
        stateNxt    = RSP;
      end
      RSP: begin
        if (bus.iRspReady) begin
          rspValidNxt = 1'b0;
          stateNxt    = IDLE;
        end
      end
`ifdef DPRAM_RMW_BYTE_EN
      RMW_RD: begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          ramDataNxt[8*b +: 8] = beQ[b] ? ramData[8*b +: 8] : bus.iRamData[8*b +: 8];
        end
        ramEnNxt = 1'b1;
        ramWeNxt = 1'b1;
        stateNxt = RMW_WR;
      end
      RMW_WR: stateNxt = IDLE;
`endif
      default: stateNxt = IDLE;
    endcase
  end

  assign bus.oReqReady = (state == IDLE) && !iRst;
  assign bus.oRspValid = rspValid;
  assign bus.oRspData  = rspData;
  assign bus.oRamEn    = ramEn;
  assign bus.oRamWe    = ramWe;
  assign bus.oRamAddr  = ramAddr;
  assign bus.oRamData  = ramData;
endmodule
